// File: rtl/nand_bank_pipe.sv
// Bank of CHANNELS reduction gates with per-channel runtime function select,
// one valid/ready output register and saturating per-channel output-transition counters.
module nand_bank_pipe #(
  parameter int CHANNELS = 2,
  parameter int INPUTS   = 4,
  parameter int CNT_W    = 8,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*INPUTS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS-1:0]       out_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic [SEL_W-1:0]          cfg_chan,
  input  logic [2:0]                cfg_func,
  input  logic                      cnt_clr,
  output logic [CHANNELS*CNT_W-1:0] tog_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on the output register state and out_ready,
  // never on in_valid, so upstream may use it to decide whether to assert valid.

  localparam logic [2:0] F_AND  = 3'd1;
  localparam logic [2:0] F_NOR  = 3'd2;
  localparam logic [2:0] F_OR   = 3'd3;
  localparam logic [2:0] F_XOR  = 3'd4;
  localparam logic [2:0] F_XNOR = 3'd5;

  logic                accept;
  logic [2:0]          func_q [CHANNELS];
  logic [CHANNELS-1:0] ref_q;
  logic [CHANNELS-1:0] gate_y;
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Codes 0, 6 and 7 all fall to the default NAND arm.
  always_comb begin
    gate_y = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (func_q[c])
        F_AND:   gate_y[c] = &in_data[c*INPUTS +: INPUTS];
        F_NOR:   gate_y[c] = ~|in_data[c*INPUTS +: INPUTS];
        F_OR:    gate_y[c] = |in_data[c*INPUTS +: INPUTS];
        F_XOR:   gate_y[c] = ^in_data[c*INPUTS +: INPUTS];
        F_XNOR:  gate_y[c] = ~^in_data[c*INPUTS +: INPUTS];
        default: gate_y[c] = ~&in_data[c*INPUTS +: INPUTS];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_y     <= '1;
      ref_q     <= '1;
      for (int c = 0; c < CHANNELS; c++) begin
        func_q[c] <= 3'd0;
        cnt_q[c]  <= '0;
      end
    end else begin
      if (accept) begin
        out_y     <= gate_y;
        out_valid <= 1'b1;
        ref_q     <= gate_y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // gate_y above was computed from the pre-write function, so a same-cycle
      // config write only affects later accepts.
      for (int c = 0; c < CHANNELS; c++) begin
        if (cfg_we && (cfg_chan == SEL_W'(c))) begin
          func_q[c] <= cfg_func;
        end
        if (cnt_clr) begin
          cnt_q[c] <= '0;
        end else if (accept && (gate_y[c] != ref_q[c]) && (cnt_q[c] != {CNT_W{1'b1}})) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    assign tog_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_nand_bank_pipe.sv
// Bench for nand_bank_pipe: directed scenarios plus randomized traffic checked
// against a behavioural model (ones-count gate rules, one-slot output, scoreboard queue).
module tb_nand_bank_pipe;
  localparam int CH   = 3;
  localparam int IN   = 4;
  localparam int CW   = 2;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH*IN-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CH-1:0]     out_y;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [SW-1:0]     cfg_chan;
  logic [2:0]        cfg_func;
  logic              cnt_clr;
  logic [CH*CW-1:0]  tog_cnt;

  always #5 clk = ~clk;

  nand_bank_pipe #(.CHANNELS(CH), .INPUTS(IN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready), .cfg_we(cfg_we),
    .cfg_chan(cfg_chan), .cfg_func(cfg_func), .cnt_clr(cnt_clr), .tog_cnt(tog_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  int            m_func [CH];
  bit            m_ref  [CH];
  int            m_cnt  [CH];
  bit            m_valid;
  logic [CH-1:0] m_y;
  logic [CH-1:0] exp_q [$];

  bit            cons_fire;
  logic [CH-1:0] cons_y;
  logic          ready_seen;
  logic          ready_exp;

  function automatic bit gate_ref(int f, logic [IN-1:0] d);
    int ones = 0;
    for (int i = 0; i < IN; i++) if (d[i]) ones++;
    case (f)
      1:       return ones == IN;
      2:       return ones == 0;
      3:       return ones != 0;
      4:       return (ones % 2) == 1;
      5:       return (ones % 2) == 0;
      default: return ones != IN;
    endcase
  endfunction

  function automatic logic [CH*CW-1:0] m_tog();
    logic [CH*CW-1:0] t;
    for (int c = 0; c < CH; c++) t[c*CW +: CW] = CW'(m_cnt[c]);
    return t;
  endfunction

  task automatic model_edge();
    bit            acc;
    logic [CH-1:0] ny;
    if (reset) begin
      m_valid = 0;
      m_y     = '1;
      for (int c = 0; c < CH; c++) begin
        m_func[c] = 0; m_ref[c] = 1; m_cnt[c] = 0;
      end
      exp_q.delete();
      return;
    end
    acc = in_valid && (!m_valid || out_ready);
    if (acc) begin
      for (int c = 0; c < CH; c++) ny[c] = gate_ref(m_func[c], in_data[c*IN +: IN]);
      for (int c = 0; c < CH; c++) begin
        if ((ny[c] != m_ref[c]) && (m_cnt[c] < CMAX)) m_cnt[c]++;
        m_ref[c] = ny[c];
      end
      m_y     = ny;
      m_valid = 1;
      exp_q.push_back(ny);
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (cnt_clr) for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    if (cfg_we && (int'(cfg_chan) < CH)) m_func[int'(cfg_chan)] = int'(cfg_func);
  endtask

  // Samples the pre-edge view, advances the model, then returns 1 ns after the edge.
  task automatic tick();
    @(negedge clk);
    ready_exp  = !m_valid || out_ready;
    ready_seen = in_ready;
    cons_fire  = out_valid && out_ready && !reset;
    cons_y     = out_y;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; cfg_we = 0; cnt_clr = 0; cfg_chan = '0; cfg_func = '0;
  endtask

  task automatic drain();
    idle();
    out_ready = 1;
    tick();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1; idle(); out_ready = 0; in_data = '0;
    tick(); tick();
    reset = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_y !== 3'b111) begin failures++; $display("FAIL reset_y got=%b exp=111", out_y); end
    checks++; if (tog_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", tog_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_defaults();
    in_data = {4'b0000, 4'b0111, 4'b1111};
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL def_valid got=%b exp=1", out_valid); end
    checks++; if (out_y !== 3'b110) begin failures++; $display("FAIL def_y got=%b exp=110", out_y); end
    checks++; if (tog_cnt !== {2'd0, 2'd0, 2'd1}) begin failures++; $display("FAIL def_cnt got=%h exp=%h", tog_cnt, {2'd0, 2'd0, 2'd1}); end
  endtask

  task automatic test_backpressure();
    logic [CH-1:0] e;
    drain();
    out_ready = 0; in_valid = 1;
    in_data = {4'b0000, 4'b0111, 4'b1111};
    tick();
    checks++; if (out_y !== 3'b110 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_first got=%b/%b exp=110/1", out_y, out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
    in_data = {4'b1111, 4'b1111, 4'b0000};
    tick(); tick();
    checks++; if (ready_seen !== 1'b0) begin failures++; $display("FAIL bp_ready_held got=%b exp=0", ready_seen); end
    checks++; if (out_y !== 3'b110 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_held got=%b/%b exp=110/1", out_y, out_valid); end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      in_valid = 0;
      if (k == 0) begin
        checks++; if (out_y !== 3'b001 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got=%b/%b exp=001/1", out_y, out_valid); end
      end
      if (cons_fire) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (cons_y !== e) begin failures++; $display("FAIL bp_consume got=%b exp=%b", cons_y, e); end
      end
    end
    checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL bp_drained got=%b left=%0d exp=0/0", out_valid, exp_q.size()); end
  endtask

  task automatic test_func_switch();
    drain();
    cfg_we = 1; cfg_chan = 2'd1; cfg_func = 3'd4;
    in_valid = 1; in_data = {4'b0000, 4'b0111, 4'b0000};
    tick();
    cfg_we = 0;
    checks++; if (out_y[1] !== 1'b1) begin failures++; $display("FAIL sw_old_func got=%b exp=1", out_y[1]); end
    tick();
    checks++; if (out_y[1] !== 1'b1) begin failures++; $display("FAIL sw_xor_odd got=%b exp=1", out_y[1]); end
    in_data = {4'b0000, 4'b0011, 4'b0000};
    tick();
    in_valid = 0;
    checks++; if (out_y[1] !== 1'b0) begin failures++; $display("FAIL sw_xor_even got=%b exp=0", out_y[1]); end
  endtask

  task automatic test_invalid_cfg();
    drain();
    cfg_we = 1; cfg_chan = 2'd3; cfg_func = 3'd1;
    tick();
    cfg_we = 0; in_valid = 1; in_data = {4'b1111, 4'b1111, 4'b1111};
    tick();
    in_valid = 0;
    checks++; if (out_y !== 3'b000) begin failures++; $display("FAIL inv_chan got=%b exp=000", out_y); end
    cfg_we = 1; cfg_chan = 2'd0; cfg_func = 3'd6;
    tick();
    cfg_chan = 2'd2; cfg_func = 3'd7;
    tick();
    cfg_we = 0; in_valid = 1; in_data = {4'b0000, 4'b0000, 4'b1111};
    tick();
    checks++; if ({out_y[2], out_y[0]} !== 2'b10) begin failures++; $display("FAIL rsv_nand_a got=%b exp=10", {out_y[2], out_y[0]}); end
    in_data = {4'b1110, 4'b0000, 4'b1110};
    tick();
    in_valid = 0;
    checks++; if ({out_y[2], out_y[0]} !== 2'b11) begin failures++; $display("FAIL rsv_nand_b got=%b exp=11", {out_y[2], out_y[0]}); end
  endtask

  task automatic test_saturation();
    drain();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++; if (tog_cnt !== '0) begin failures++; $display("FAIL sat_clr got=%h exp=0", tog_cnt); end
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_data = {8'h00, (m_ref[0] ? 4'b1111 : 4'b0000)};
      tick();
      if (k == 2 || k == 4) begin
        checks++; if (tog_cnt[CW-1:0] !== 2'd3) begin failures++; $display("FAIL sat_ch0 got=%0d exp=3", tog_cnt[CW-1:0]); end
      end
    end
    checks++; if (tog_cnt !== m_tog()) begin failures++; $display("FAIL sat_all got=%h exp=%h", tog_cnt, m_tog()); end
    in_data = {8'h00, (m_ref[0] ? 4'b1111 : 4'b0000)};
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++; if (tog_cnt !== '0) begin failures++; $display("FAIL sat_clr_prio got=%h exp=0", tog_cnt); end
    in_data = {8'h00, (m_ref[0] ? 4'b1111 : 4'b0000)};
    tick();
    in_valid = 0;
    checks++; if (tog_cnt[CW-1:0] !== 2'd1) begin failures++; $display("FAIL sat_after_clr got=%0d exp=1", tog_cnt[CW-1:0]); end
  endtask

  task automatic test_reset_mid();
    drain();
    cfg_we = 1; cfg_chan = 2'd2; cfg_func = 3'd3;
    tick();
    cfg_we = 0; out_ready = 0; in_valid = 1; in_data = {4'b1111, 4'b1111, 4'b0000};
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", out_valid); end
    reset = 1; cfg_we = 1; cfg_chan = 2'd1; cfg_func = 3'd1;
    tick();
    reset = 0; idle();
    checks++; if (out_valid !== 1'b0 || out_y !== 3'b111) begin failures++; $display("FAIL mid_out got=%b/%b exp=0/111", out_valid, out_y); end
    checks++; if (tog_cnt !== '0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_cnt_rdy got=%h/%b exp=0/1", tog_cnt, in_ready); end
    in_valid = 1; out_ready = 1; in_data = {4'b0000, 4'b0011, 4'b1111};
    tick();
    in_valid = 0;
    checks++; if (out_y !== 3'b110) begin failures++; $display("FAIL mid_func got=%b exp=110", out_y); end
    checks++; if (tog_cnt !== {2'd0, 2'd0, 2'd1}) begin failures++; $display("FAIL mid_ref got=%h exp=%h", tog_cnt, {2'd0, 2'd0, 2'd1}); end
  endtask

  task automatic test_random();
    logic [CH-1:0] e;
    drain();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = (CH*IN)'($urandom());
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_chan  = SW'($urandom_range(0, 3));
      cfg_func  = 3'($urandom_range(0, 7));
      cnt_clr   = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      tick();
      checks++; if (ready_seen !== ready_exp) begin failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, ready_seen, ready_exp); end
      if (cons_fire) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (cons_y !== e) begin failures++; $display("FAIL rnd_consume n=%0d got=%b exp=%b", n, cons_y, e); end
      end
      checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, m_valid); end
      checks++; if (out_y !== m_y) begin failures++; $display("FAIL rnd_y n=%0d got=%b exp=%b", n, out_y, m_y); end
      checks++; if (tog_cnt !== m_tog()) begin failures++; $display("FAIL rnd_cnt n=%0d got=%h exp=%h", n, tog_cnt, m_tog()); end
    end
    reset = 0; idle();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_backpressure();
    test_func_switch();
    test_invalid_cfg();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
